// File: rtl/fx3_egress_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fx3_egress_arbiter_pkg
//   Shared definitions for the fx3 egress arbiter:
//   - FSM state encodings (3-bit, kept as plain constants for older tools)
//   - egress header field positions
//   - minimum legal egress buffer size
//   - make_header(): builds the header word that prefixes every chunk
// ---------------------------------------------------------------------------
package fx3_egress_arbiter_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_EG_ACQ  = 3'd2;
    localparam logic [2:0] ST_HEADER  = 3'd3;
    localparam logic [2:0] ST_PAYLOAD = 3'd4;
    localparam logic [2:0] ST_EG_REL  = 3'd5;

    localparam int LAST_BIT  = 31;
    localparam int ID_MSB    = 27;
    localparam int ID_LSB    = 24;
    localparam int COUNT_MSB = 23;

    // One header word plus at least one payload word must fit.
    localparam logic [23:0] MIN_EGRESS_SIZE = 24'd2;

    // Header: {last, 3'b000, source id, chunk word count}
    function automatic logic [31:0] make_header(input logic        last,
                                                input logic [3:0]  id,
                                                input logic [23:0] count);
        logic [31:0] h;
        h                  = '0;
        h[LAST_BIT]        = last;
        h[ID_MSB:ID_LSB]   = id;
        h[COUNT_MSB:0]     = count;
        return h;
    endfunction

endpackage

// File: rtl/fx3_egress_arbiter_if.sv
// ---------------------------------------------------------------------------
// fx3_egress_arbiter_if
//   Bundles the two upstream FIFO read sides and the egress FIFO write side.
//
//   Handshake: a FIFO owner raises *_ready when a buffer is available; the
//   consumer takes ownership by raising *_activate and holds it until done.
//   While activated, *_strobe is a single-cycle transfer qualifier: one word
//   moves on every clock edge where strobe is high, and strobe is only ever
//   high while the matching activate is high. Source data is
//   first-word-fall-through and advances the cycle after a strobe.
//
//   Modports:
//     slave  - the arbiter (consumes i_*, drives o_*)
//     master - the surrounding FIFOs / environment
// ---------------------------------------------------------------------------
interface fx3_egress_arbiter_if;

    logic        i_src0_ready;
    logic        o_src0_activate;
    logic [23:0] i_src0_size;
    logic [31:0] i_src0_data;
    logic        o_src0_strobe;

    logic        i_src1_ready;
    logic        o_src1_activate;
    logic [23:0] i_src1_size;
    logic [31:0] i_src1_data;
    logic        o_src1_strobe;

    logic [1:0]  i_egress_ready;
    logic [1:0]  o_egress_activate;
    logic [23:0] i_egress_size;
    logic [31:0] o_egress_data;
    logic        o_egress_strobe;

    modport slave (
        input  i_src0_ready, i_src0_size, i_src0_data,
        output o_src0_activate, o_src0_strobe,
        input  i_src1_ready, i_src1_size, i_src1_data,
        output o_src1_activate, o_src1_strobe,
        input  i_egress_ready, i_egress_size,
        output o_egress_activate, o_egress_data, o_egress_strobe
    );

    modport master (
        output i_src0_ready, i_src0_size, i_src0_data,
        input  o_src0_activate, o_src0_strobe,
        output i_src1_ready, i_src1_size, i_src1_data,
        input  o_src1_activate, o_src1_strobe,
        output i_egress_ready, i_egress_size,
        input  o_egress_activate, o_egress_data, o_egress_strobe
    );

endinterface

// File: rtl/fx3_rr_pick.sv
// ---------------------------------------------------------------------------
// fx3_rr_pick
//   Two-requester round-robin selector (purely combinational).
//   Ports:
//     req        in  2  request bits {src1, src0}
//     last_grant in  1  index of the source served most recently
//     grant      out 2  one-hot winner, zero when nobody requests
//   On a tie the source that was not served last wins.
// ---------------------------------------------------------------------------
module fx3_rr_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/fx3_egress_arbiter.sv
// ---------------------------------------------------------------------------
// fx3_egress_arbiter
//   Shares the single fx3_bus egress ping-pong FIFO between two upstream
//   ping-pong FIFO read sides. One source buffer is drained at a time and cut
//   into egress-sized chunks; each chunk is preceded by a header word
//   {last, 3'b000, id, count} so the host can demultiplex the stream.
//
//   Ports:
//     clk      in   1  clock
//     rst_n    in   1  asynchronous active-low reset
//     bus      if      source/egress FIFO signals (slave modport)
//     o_grant  out  2  one-hot source currently served
//     o_busy   out  1  FSM not idle
//     o_state  out  3  FSM state (debug visibility)
// ---------------------------------------------------------------------------
module fx3_egress_arbiter
    import fx3_egress_arbiter_pkg::*;
#(
    parameter logic [3:0] SRC0_ID = 4'h0,
    parameter logic [3:0] SRC1_ID = 4'h1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    fx3_egress_arbiter_if.slave         bus,
    output logic [1:0]                  o_grant,
    output logic                        o_busy,
    output logic [2:0]                  o_state
);

    logic [2:0]  state;
    logic        last_grant;     // 0 = src0 served last, 1 = src1
    logic [1:0]  grant;          // doubles as the source activate pair
    logic [23:0] remaining;
    logic [23:0] chunk;
    logic [23:0] cnt;
    logic        last;
    logic [1:0]  eg_act;
    logic [31:0] eg_data;
    logic        eg_strobe;

    logic [1:0]  pick;
    logic [31:0] src_data;
    logic [23:0] src_size;
    logic [3:0]  src_id;
    logic [23:0] size_m1;
    logic [23:0] next_chunk;
    logic        next_last;
    logic        pop;
    logic [1:0]  eg_pick;

    fx3_rr_pick u_rr_pick (
        .req        ({bus.i_src1_ready, bus.i_src0_ready}),
        .last_grant (last_grant),
        .grant      (pick)
    );

    always_comb begin
        src_data = grant[1] ? bus.i_src1_data : bus.i_src0_data;
        src_size = grant[1] ? bus.i_src1_size : bus.i_src0_size;
        src_id   = grant[1] ? SRC1_ID         : SRC0_ID;

        // Room left after the header word. An illegal (too small) egress
        // size is clamped so a chunk can never be zero and stall the FSM.
        if (bus.i_egress_size < MIN_EGRESS_SIZE) begin
            size_m1 = 24'd1;
        end else begin
            size_m1 = bus.i_egress_size - 24'd1;
        end
        next_chunk = (remaining < size_m1) ? remaining : size_m1;
        next_last  = (next_chunk == remaining);

        // Lowest free egress buffer wins.
        if (bus.i_egress_ready[0]) begin
            eg_pick = 2'b01;
        end else if (bus.i_egress_ready[1]) begin
            eg_pick = 2'b10;
        end else begin
            eg_pick = 2'b00;
        end

        pop = (state == ST_PAYLOAD) && (cnt < chunk);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            grant      <= 2'b00;
            remaining  <= '0;
            chunk      <= '0;
            cnt        <= '0;
            last       <= 1'b0;
            eg_act     <= 2'b00;
            eg_data    <= '0;
            eg_strobe  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick != 2'b00) begin
                        grant      <= pick;
                        last_grant <= pick[1];
                        state      <= ST_CHECK;
                    end
                end

                // The size input is only valid once the source is activated.
                ST_CHECK: begin
                    if (src_size == 24'd0) begin
                        grant <= 2'b00;
                        state <= ST_IDLE;
                    end else begin
                        remaining <= src_size;
                        state     <= ST_EG_ACQ;
                    end
                end

                // First cycle claims an egress buffer; the cycle after, its
                // size is valid and the chunk and header are formed.
                ST_EG_ACQ: begin
                    if (eg_act == 2'b00) begin
                        if (bus.i_egress_ready != 2'b00) begin
                            eg_act <= eg_pick;
                        end
                    end else begin
                        chunk     <= next_chunk;
                        last      <= next_last;
                        eg_data   <= make_header(next_last, src_id, next_chunk);
                        eg_strobe <= 1'b1;
                        state     <= ST_HEADER;
                    end
                end

                ST_HEADER: begin
                    eg_strobe <= 1'b0;
                    cnt       <= '0;
                    state     <= ST_PAYLOAD;
                end

                // Each popped word is written one cycle later; the cycle that
                // finds cnt == chunk is the one writing the final word.
                ST_PAYLOAD: begin
                    if (pop) begin
                        eg_data   <= src_data;
                        eg_strobe <= 1'b1;
                        cnt       <= cnt + 24'd1;
                    end else begin
                        eg_strobe <= 1'b0;
                        state     <= ST_EG_REL;
                    end
                end

                ST_EG_REL: begin
                    eg_act    <= 2'b00;
                    remaining <= remaining - chunk;
                    if (last) begin
                        grant <= 2'b00;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_EG_ACQ;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_src0_activate   = grant[0];
    assign bus.o_src1_activate   = grant[1];
    assign bus.o_src0_strobe     = pop & grant[0];
    assign bus.o_src1_strobe     = pop & grant[1];
    assign bus.o_egress_activate = eg_act;
    assign bus.o_egress_data     = eg_data;
    assign bus.o_egress_strobe   = eg_strobe;

    assign o_grant = grant;
    assign o_busy  = (state != ST_IDLE);
    assign o_state = state;

endmodule
